axil_dual_port_ram: RTL and testbench



---
 rtl/axil_dual_port_ram_pkg.sv | 13 +
 rtl/axil_ram_port.sv | 110 +++++++++++
 rtl/axil_dual_port_ram.sv | 135 +++++++++++++
 tb/tb_axil_dual_port_ram.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_dual_port_ram_pkg.sv
// Shared definitions for the AXI4-Lite dual-port RAM: response codes and
// the helper that turns a byte-address width into a word-address width.
package axil_dual_port_ram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Word-address width: byte-address width minus the byte-lane bits.
   function automatic int word_addr_width(input int addr_width, input int strb_width);
      return addr_width - $clog2(strb_width);
   endfunction

endpackage

// File: rtl/axil_ram_port.sv
// Per-port AXI4-Lite handshake engine: write accept, read accept and the
// bvalid/rvalid hold logic. The storage array lives in the parent.
// Optional macro AXIL_DUAL_PORT_RAM_OUTREG_EN adds one read output register
// stage (two-cycle read latency, arready still pulses one cycle after arvalid).
module axil_ram_port
   import axil_dual_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  awvalid,
   input  logic                  wvalid,
   input  logic                  bready,
   input  logic                  arvalid,
   input  logic                  rready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  awready,
   output logic                  wready,
   output logic                  bvalid,
   output logic [1:0]            bresp,
   output logic                  arready,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  wr_en
);

   logic wr_acc;
   logic rd_acc;

   // Both address and data must be present; the ready pulse blocks re-acceptance
   // on the following edge. resetn gates the strobe so a held reset never writes.
   assign wr_acc = resetn && awvalid && wvalid && !awready && !wready && (!bvalid || bready);
   assign wr_en  = wr_acc;
   assign bresp  = RESP_OKAY;
   assign rresp  = RESP_OKAY;

   // Write channel: ready pulse and bvalid hold until the response is taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         awready <= wr_acc;
         wready  <= wr_acc;
         if (wr_acc) begin
            bvalid <= 1'b1;
         end else if (bready) begin
            bvalid <= 1'b0;
         end
      end
   end

`ifdef AXIL_DUAL_PORT_RAM_OUTREG_EN
   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] rdata_p1;

   // Only one read may be in flight: the stage-1 slot must be empty and the
   // output register must be free or draining this edge.
   assign rd_acc = arvalid && !arready && !vld_p1 && (!rvalid || rready);

   // Read control: stage-1 valid moves into the output register next edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arready <= 1'b0;
         vld_p1  <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else begin
         arready <= rd_acc;
         vld_p1  <= rd_acc;
         if (vld_p1) begin
            rvalid <= 1'b1;
            rdata  <= rdata_p1;
         end else if (rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // Stage 1: capture the array word at the accept edge (read-before-write).
   always_ff @(posedge clk) begin
      if (rd_acc) begin
         rdata_p1 <= mem_rdata;
      end
   end
`else
   assign rd_acc = arvalid && !arready && (!rvalid || rready);

   // Read channel: capture the array word at the accept edge and hold it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else begin
         arready <= rd_acc;
         if (rd_acc) begin
            rvalid <= 1'b1;
            rdata  <= mem_rdata;
         end else if (rready) begin
            rvalid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: rtl/axil_dual_port_ram.sv
// AXI4-Lite dual-port RAM: two independent slave ports (A = CPU side,
// B = external loader) sharing one word-addressed array on a single clock.
// Optional macro AXIL_DUAL_PORT_RAM_OUTREG_EN adds a read output register
// stage per port (handled inside axil_ram_port).
module axil_dual_port_ram
   import axil_dual_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   // Port A
   input  logic [ADDR_WIDTH-1:0] s_axil_a_awaddr,
   input  logic [2:0]            s_axil_a_awprot,
   input  logic                  s_axil_a_awvalid,
   output logic                  s_axil_a_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_a_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_a_wstrb,
   input  logic                  s_axil_a_wvalid,
   output logic                  s_axil_a_wready,
   output logic [1:0]            s_axil_a_bresp,
   output logic                  s_axil_a_bvalid,
   input  logic                  s_axil_a_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_a_araddr,
   input  logic [2:0]            s_axil_a_arprot,
   input  logic                  s_axil_a_arvalid,
   output logic                  s_axil_a_arready,
   output logic [DATA_WIDTH-1:0] s_axil_a_rdata,
   output logic [1:0]            s_axil_a_rresp,
   output logic                  s_axil_a_rvalid,
   input  logic                  s_axil_a_rready,
   // Port B
   input  logic [ADDR_WIDTH-1:0] s_axil_b_awaddr,
   input  logic [2:0]            s_axil_b_awprot,
   input  logic                  s_axil_b_awvalid,
   output logic                  s_axil_b_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_b_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_b_wstrb,
   input  logic                  s_axil_b_wvalid,
   output logic                  s_axil_b_wready,
   output logic [1:0]            s_axil_b_bresp,
   output logic                  s_axil_b_bvalid,
   input  logic                  s_axil_b_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_b_araddr,
   input  logic [2:0]            s_axil_b_arprot,
   input  logic                  s_axil_b_arvalid,
   output logic                  s_axil_b_arready,
   output logic [DATA_WIDTH-1:0] s_axil_b_rdata,
   output logic [1:0]            s_axil_b_rresp,
   output logic                  s_axil_b_rvalid,
   input  logic                  s_axil_b_rready
);

   localparam int WORD_AW  = word_addr_width(ADDR_WIDTH, STRB_WIDTH);
   localparam int ADDR_LSB = ADDR_WIDTH - WORD_AW;
   localparam int DEPTH    = 2 ** WORD_AW;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [WORD_AW-1:0]    a_wr_idx, a_rd_idx, b_wr_idx, b_rd_idx;
   logic [DATA_WIDTH-1:0] a_mem_rdata, b_mem_rdata;
   logic                  a_wr_en, b_wr_en;
   logic                  unused_prot_addr;

   // Byte-offset bits and prot are don't-cares; addresses are never misaligned.
   assign a_wr_idx = s_axil_a_awaddr[ADDR_WIDTH-1:ADDR_LSB];
   assign a_rd_idx = s_axil_a_araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign b_wr_idx = s_axil_b_awaddr[ADDR_WIDTH-1:ADDR_LSB];
   assign b_rd_idx = s_axil_b_araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign unused_prot_addr = ^{s_axil_a_awprot, s_axil_a_arprot, s_axil_b_awprot, s_axil_b_arprot,
                               s_axil_a_awaddr, s_axil_a_araddr, s_axil_b_awaddr, s_axil_b_araddr};

   // Asynchronous array read; the port registers it at its accept edge, so a
   // same-edge write from the other port is not yet visible (read-before-write).
   assign a_mem_rdata = mem[a_rd_idx];
   assign b_mem_rdata = mem[b_rd_idx];

   // Array write: port B's bytes are scheduled first and port A's last, so on
   // a same-word collision A wins every byte both enable and the rest merge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (b_wr_en && s_axil_b_wstrb[i]) begin
            mem[b_wr_idx][i*8 +: 8] <= s_axil_b_wdata[i*8 +: 8];
         end
      end
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (a_wr_en && s_axil_a_wstrb[i]) begin
            mem[a_wr_idx][i*8 +: 8] <= s_axil_a_wdata[i*8 +: 8];
         end
      end
   end

   axil_ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
      .clk       (clk),
      .resetn    (resetn),
      .awvalid   (s_axil_a_awvalid),
      .wvalid    (s_axil_a_wvalid),
      .bready    (s_axil_a_bready),
      .arvalid   (s_axil_a_arvalid),
      .rready    (s_axil_a_rready),
      .mem_rdata (a_mem_rdata),
      .awready   (s_axil_a_awready),
      .wready    (s_axil_a_wready),
      .bvalid    (s_axil_a_bvalid),
      .bresp     (s_axil_a_bresp),
      .arready   (s_axil_a_arready),
      .rvalid    (s_axil_a_rvalid),
      .rdata     (s_axil_a_rdata),
      .rresp     (s_axil_a_rresp),
      .wr_en     (a_wr_en)
   );

   axil_ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
      .clk       (clk),
      .resetn    (resetn),
      .awvalid   (s_axil_b_awvalid),
      .wvalid    (s_axil_b_wvalid),
      .bready    (s_axil_b_bready),
      .arvalid   (s_axil_b_arvalid),
      .rready    (s_axil_b_rready),
      .mem_rdata (b_mem_rdata),
      .awready   (s_axil_b_awready),
      .wready    (s_axil_b_wready),
      .bvalid    (s_axil_b_bvalid),
      .bresp     (s_axil_b_bresp),
      .arready   (s_axil_b_arready),
      .rvalid    (s_axil_b_rvalid),
      .rdata     (s_axil_b_rdata),
      .rresp     (s_axil_b_rresp),
      .wr_en     (b_wr_en)
   );

endmodule

// File: tb/tb_axil_dual_port_ram.sv
// Scoreboard bench for axil_dual_port_ram: directed scenarios followed by
// randomized traffic on both ports against a word-level memory model.
module tb_axil_dual_port_ram;

   localparam int DW = 32;
   localparam int AW = 17;
   localparam int SW = 4;
`ifdef AXIL_DUAL_PORT_RAM_OUTREG_EN
   localparam int EXP_LAT = 2;
`else
   localparam int EXP_LAT = 1;
`endif

   logic clk = 1'b0;
   logic resetn;
   logic [1:0][AW-1:0] awaddr, araddr;
   logic [1:0][2:0]    awprot, arprot;
   logic [1:0]         awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]         arvalid, arready, rvalid, rready;
   logic [1:0][DW-1:0] wdata, rdata;
   logic [1:0][SW-1:0] wstrb;
   logic [1:0][1:0]    bresp, rresp;

   int checks = 0;
   int errors = 0;
   int bp_mode = 0;
   int bpend [2];
   logic [31:0] rexp0 [$];
   logic [31:0] rexp1 [$];
   logic [31:0] model_mem [int];

   always #5 clk = ~clk;

   axil_dual_port_ram dut (
      .clk(clk), .resetn(resetn),
      .s_axil_a_awaddr(awaddr[0]), .s_axil_a_awprot(awprot[0]), .s_axil_a_awvalid(awvalid[0]),
      .s_axil_a_awready(awready[0]), .s_axil_a_wdata(wdata[0]), .s_axil_a_wstrb(wstrb[0]),
      .s_axil_a_wvalid(wvalid[0]), .s_axil_a_wready(wready[0]), .s_axil_a_bresp(bresp[0]),
      .s_axil_a_bvalid(bvalid[0]), .s_axil_a_bready(bready[0]), .s_axil_a_araddr(araddr[0]),
      .s_axil_a_arprot(arprot[0]), .s_axil_a_arvalid(arvalid[0]), .s_axil_a_arready(arready[0]),
      .s_axil_a_rdata(rdata[0]), .s_axil_a_rresp(rresp[0]), .s_axil_a_rvalid(rvalid[0]),
      .s_axil_a_rready(rready[0]),
      .s_axil_b_awaddr(awaddr[1]), .s_axil_b_awprot(awprot[1]), .s_axil_b_awvalid(awvalid[1]),
      .s_axil_b_awready(awready[1]), .s_axil_b_wdata(wdata[1]), .s_axil_b_wstrb(wstrb[1]),
      .s_axil_b_wvalid(wvalid[1]), .s_axil_b_wready(wready[1]), .s_axil_b_bresp(bresp[1]),
      .s_axil_b_bvalid(bvalid[1]), .s_axil_b_bready(bready[1]), .s_axil_b_araddr(araddr[1]),
      .s_axil_b_arprot(arprot[1]), .s_axil_b_arvalid(arvalid[1]), .s_axil_b_arready(arready[1]),
      .s_axil_b_rdata(rdata[1]), .s_axil_b_rresp(rresp[1]), .s_axil_b_rvalid(rvalid[1]),
      .s_axil_b_rready(rready[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic note_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   function automatic logic [31:0] mget(input int idx);
      if (model_mem.exists(idx)) return model_mem[idx];
      return 32'h0;
   endfunction

   // Memory model: apply an acknowledged write with its byte enables.
   task automatic model_write(input int p);
      int idx;
      logic [31:0] cur;
      idx = int'(awaddr[p][AW-1:2]);
      cur = mget(idx);
      for (int b = 0; b < SW; b++)
         if (wstrb[p][b]) cur[b*8 +: 8] = wdata[p][b*8 +: 8];
      model_mem[idx] = cur;
   endtask

   // At each edge: reads see the memory before this edge's writes; B's write
   // lands before A's so A wins shared bytes. On the falling edge, pop and
   // compare every response the DUT hands over.
   task automatic scoreboard();
      logic [31:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (resetn) begin
            for (int p = 0; p < 2; p++) begin
               if (arready[p]) begin
                  e = mget(int'(araddr[p][AW-1:2]));
                  if (p == 0) rexp0.push_back(e);
                  else rexp1.push_back(e);
               end
               if (awready[p] || wready[p]) chk("wready_with_awready", 32'(wready[p]), 32'(awready[p]));
            end
            if (awready[1]) begin model_write(1); bpend[1]++; end
            if (awready[0]) begin model_write(0); bpend[0]++; end
         end
         @(negedge clk);
         if (resetn) begin
            for (int p = 0; p < 2; p++) begin
               if (rvalid[p] && rready[p]) begin
                  if (p == 0 && rexp0.size() == 0) note_fail("rdata_unexpected_a");
                  else if (p == 1 && rexp1.size() == 0) note_fail("rdata_unexpected_b");
                  else begin
                     e = (p == 0) ? rexp0.pop_front() : rexp1.pop_front();
                     chk(p == 0 ? "rdata_a" : "rdata_b", rdata[p], e);
                     chk("rresp", 32'(rresp[p]), 32'h0);
                  end
               end
               if (bvalid[p] && bready[p]) begin
                  if (bpend[p] == 0) note_fail("bvalid_unexpected");
                  else begin
                     bpend[p]--;
                     chk("bresp", 32'(bresp[p]), 32'h0);
                  end
               end
            end
         end
      end
   endtask

   task automatic apply_bp();
      case (bp_mode)
         0: begin bready = 2'b11; rready = 2'b11; end
         1: begin
            bready = {($urandom % 4) != 0, ($urandom % 4) != 0};
            rready = {($urandom % 4) != 0, ($urandom % 4) != 0};
         end
         default: begin bready = 2'b00; rready = 2'b00; end
      endcase
   endtask

   task automatic set_bp(input int m);
      bp_mode = m;
      apply_bp();
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk);
         #2;
         apply_bp();
      end
   endtask

   // which: 0 = arready, 1 = rvalid, 2 = awready
   task automatic wait_hi(input int p, input int which, input string nm, output int n);
      logic s;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
         s = (which == 0) ? arready[p] : (which == 1) ? rvalid[p] : awready[p];
      end while (!s && n < 200);
      if (!s) note_fail(nm);
   endtask

   task automatic do_write(input int p, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int n;
      awaddr[p] = a; wdata[p] = d; wstrb[p] = s;
      awvalid[p] = 1'b1; wvalid[p] = 1'b1;
      wait_hi(p, 2, "awready_timeout", n);
      chk("bvalid_after_accept", 32'(bvalid[p]), 32'h1);
      awvalid[p] = 1'b0; wvalid[p] = 1'b0;
   endtask

   task automatic do_read(input int p, input logic [AW-1:0] a, input bit wait_r, output int lat);
      int n, m;
      araddr[p] = a;
      arvalid[p] = 1'b1;
      wait_hi(p, 0, "arready_timeout", n);
      arvalid[p] = 1'b0;
      lat = n;
      if (wait_r && !rvalid[p]) begin
         wait_hi(p, 1, "rvalid_timeout", m);
         lat = n + m;
      end
   endtask

   task automatic idle(input int c);
      repeat (c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic port_rand(input int p);
      int lat;
      logic [AW-1:0] a;
      for (int i = 0; i < 60; i++) begin
         a = AW'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         if ($urandom % 2) do_write(p, a, $urandom, 4'($urandom_range(0, 15)));
         else do_read(p, a, 1'b0, lat);
         idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      int lat, n;
      resetn = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = '0; wvalid = '0; arvalid = '0; wdata = '0; wstrb = '0;
      bpend[0] = 0; bpend[1] = 0;
      set_bp(0);
      fork
         scoreboard();
         ready_drv();
      join_none
      repeat (3) @(posedge clk);
      #2;
      for (int p = 0; p < 2; p++) begin
         chk("reset_ready_valid", 32'({awready[p], wready[p], bvalid[p], arready[p], rvalid[p]}), 32'h0);
         chk("reset_rdata", rdata[p], 32'h0);
         chk("reset_resp", 32'({bresp[p], rresp[p]}), 32'h0);
      end
      resetn = 1'b1;
      idle(2);

      // Basic write then read with latency
      do_write(0, 17'h100, 32'hDEADBEEF, 4'hF);
      idle(1);
      do_read(0, 17'h100, 1'b1, lat);
      chk("read_latency", 32'(lat), 32'(EXP_LAT));
      chk("t1_rdata", rdata[0], 32'hDEADBEEF);
      idle(2);

      // Strobed merge across ports
      do_write(1, 17'h0, 32'h11223344, 4'hF);
      do_write(0, 17'h0, 32'hAABBCCDD, 4'b0101);
      do_read(0, 17'h0, 1'b1, lat);
      chk("t2_merge", rdata[0], 32'h11BB33DD);
      idle(2);

      // Same-word same-edge writes: A wins
      fork
         do_write(0, 17'h0, 32'h00000000, 4'hF);
         do_write(1, 17'h0, 32'hFFFFFFFF, 4'hF);
      join
      do_read(0, 17'h0, 1'b1, lat);
      chk("t3_collide_a", rdata[0], 32'h0);
      do_read(1, 17'h0, 1'b1, lat);
      chk("t3_collide_b", rdata[1], 32'h0);
      idle(2);

      // Lone awvalid is never accepted
      awaddr[0] = 17'h40; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF; awvalid[0] = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #2;
         chk("lone_aw_no_ready", 32'({awready[0], wready[0]}), 32'h0);
      end
      do_write(0, 17'h40, 32'hCAFEF00D, 4'hF);
      idle(3);
      chk("single_write_bpend", 32'(bpend[0]), 32'h0);
      do_read(0, 17'h40, 1'b1, lat);
      chk("t4_readback", rdata[0], 32'hCAFEF00D);
      idle(2);

      // rready held low blocks a second read; data held
      set_bp(2);
      araddr[0] = 17'h100; arvalid[0] = 1'b1;
      wait_hi(0, 0, "t5_arready_timeout", n);
      araddr[0] = 17'h0;
      if (!rvalid[0]) wait_hi(0, 1, "t5_rvalid_timeout", n);
      repeat (5) begin
         @(posedge clk);
         #2;
         chk("t5_no_second_arready", 32'(arready[0]), 32'h0);
         chk("t5_rdata_hold", rdata[0], 32'hDEADBEEF);
         chk("t5_rvalid_hold", 32'(rvalid[0]), 32'h1);
      end
      set_bp(0);
      wait_hi(0, 0, "t5_second_arready_timeout", n);
      arvalid[0] = 1'b0;
      idle(4);

      // Asynchronous reset with responses pending
      set_bp(2);
      do_write(0, 17'h80, 32'h5A5A1234, 4'hF);
      do_read(0, 17'h100, 1'b1, lat);
      #1;
      resetn = 1'b0;
      #1;
      chk("async_reset_bvalid", 32'(bvalid[0]), 32'h0);
      chk("async_reset_awready", 32'(awready[0]), 32'h0);
      chk("async_reset_rvalid", 32'(rvalid[0]), 32'h0);
      rexp0.delete(); rexp1.delete();
      bpend[0] = 0; bpend[1] = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_rdata_cleared", rdata[0], 32'h0);
      resetn = 1'b1;
      set_bp(0);
      idle(1);
      do_read(0, 17'h80, 1'b1, lat);
      chk("array_kept_over_reset", rdata[0], 32'h5A5A1234);
      idle(2);

      // Randomized traffic on both ports over a small shared word pool
      for (int w = 0; w < 8; w++) do_write(1, AW'(w * 4), $urandom, 4'hF);
      set_bp(1);
      fork
         port_rand(0);
         port_rand(1);
      join
      set_bp(0);
      idle(20);
      chk("drain_rexp_a", 32'(rexp0.size()), 32'h0);
      chk("drain_rexp_b", 32'(rexp1.size()), 32'h0);
      chk("drain_bpend_a", 32'(bpend[0]), 32'h0);
      chk("drain_bpend_b", 32'(bpend[1]), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
